// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, state
// encodings and the shared-ALU control encodings it drives.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // Shared ALU-control encodings ({funct7[5], funct3} style)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: absolute value of an operand when fed
// its sign bit, or final sign correction of a product/quotient/remainder.
module muldiv_signfix #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a,
  input  logic             neg,
  output logic [Width-1:0] y
);

  assign y = neg ? (~a + Width'(1)) : a;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer borrowing the EX-stage ALU for its add/sub steps.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier is exhausted.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_sel,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] alu_res
);

  localparam int unsigned     CntW    = $clog2(ITERS);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITERS - 1);

  state_e          state_q;
  logic [2:0]      op_q;
  // hi_q: product high / remainder; lo_q: multiplier / quotient; dvs_q: multiplicand / divisor
  logic [XLEN-1:0] hi_q, lo_q, dvs_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  logic is_div, is_rem, sgn1, sgn2, neg1, neg2;

  assign is_div = op_q[2];
  assign is_rem = op_q[2] & op_q[1];
  assign sgn1   = is_div ? ~op_q[0] : (op_q == MD_MULH || op_q == MD_MULHSU);
  assign sgn2   = is_div ? ~op_q[0] : (op_q == MD_MULH);
  // In PREP, lo_q still holds rs1 and dvs_q holds rs2
  assign neg1   = sgn1 & lo_q[XLEN-1];
  assign neg2   = sgn2 & dvs_q[XLEN-1];

  logic [XLEN-1:0] abs1, abs2;

  muldiv_signfix #(.Width(XLEN)) u_abs1 (
    .a   (lo_q),
    .neg (neg1),
    .y   (abs1)
  );

  muldiv_signfix #(.Width(XLEN)) u_abs2 (
    .a   (dvs_q),
    .neg (neg2),
    .y   (abs2)
  );

  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign div_zero    = is_div & (dvs_q == '0);
  assign div_ovf     = is_div & ~op_q[0] & (lo_q == {1'b1, {(XLEN-1){1'b0}}}) & (dvs_q == '1);
  assign special     = div_zero | div_ovf;
  assign special_res = div_zero ? (is_rem ? lo_q : '1) : (is_rem ? '0 : lo_q);

  // Iteration step datapath
  logic [XLEN-1:0]   rem_sh, mul_sum, div_hi_next, div_lo_next;
  logic              mul_carry, div_take, mul_exit;
  logic [2*XLEN-1:0] mul_next, mul_algn;

  assign rem_sh      = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign div_take    = hi_q[XLEN-1] | (rem_sh >= dvs_q);
  assign div_hi_next = div_take ? alu_res : rem_sh;
  assign div_lo_next = {lo_q[XLEN-2:0], div_take};

  assign mul_carry = lo_q[0] & (alu_res < hi_q);
  assign mul_sum   = lo_q[0] ? alu_res : hi_q;
  assign mul_next  = {mul_carry, mul_sum, lo_q[XLEN-1:1]};

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] rem_mask;

  // Mask of multiplier bits still unconsumed after this step
  assign rem_mask = {XLEN{1'b1}} >> ({1'b0, cnt_q} + (CntW+1)'(1));
  assign mul_exit = (cnt_q == LastCnt) || (((lo_q >> 1) & rem_mask) == '0);
  assign mul_algn = mul_next >> (LastCnt - cnt_q);
`else
  assign mul_exit = (cnt_q == LastCnt);
  assign mul_algn = mul_next;
`endif

  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_op1  = '0;
    alu_op2  = '0;
    if (state_q == S_ITER) begin
      if (is_div) begin
        alu_ctrl = ALU_SUB;
        alu_op1  = rem_sh;
        alu_op2  = dvs_q;
      end else begin
        alu_op1 = hi_q;
        alu_op2 = lo_q[0] ? dvs_q : '0;
      end
    end
  end

  // Final sign correction: one 64-bit negate shared by product, quotient and remainder
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   fix_res;

  assign fix_in  = is_div ? {{XLEN{1'b0}}, (is_rem ? hi_q : lo_q)} : {hi_q, lo_q};
  assign fix_res = (is_div || op_q == MD_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

  muldiv_signfix #(.Width(2 * XLEN)) u_fix (
    .a   (fix_in),
    .neg (neg_q),
    .y   (fix_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !kill) begin
            op_q    <= op;
            lo_q    <= rs1;
            dvs_q   <= rs2;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (special) begin
            result_q <= special_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            hi_q    <= '0;
            lo_q    <= is_div ? abs1 : abs2;
            dvs_q   <= is_div ? abs2 : abs1;
            neg_q   <= is_rem ? neg1 : (neg1 ^ neg2);
            cnt_q   <= '0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (is_div) begin
              hi_q <= div_hi_next;
              lo_q <= div_lo_next;
              if (cnt_q == LastCnt) state_q <= S_FIX;
            end else if (mul_exit) begin
              {hi_q, lo_q} <= mul_algn;
              state_q      <= S_FIX;
            end else begin
              {hi_q, lo_q} <= mul_next;
            end
          end
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          if (kill) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign alu_sel = (state_q == S_ITER);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, kill/reset sequences and
// randomized operations against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done, alu_sel;
  logic [31:0] result, alu_op1, alu_op2, alu_res;
  logic [3:0]  alu_ctrl;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  // Shared EX-stage ALU stand-in
  assign alu_res = (alu_ctrl == ALU_SUB) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;

  muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_sel  (alu_sel),
    .alu_ctrl (alu_ctrl),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_res  (alu_res)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = 64'(a);
    ub  = 64'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (o)
      MD_MUL:    begin p = ua * ub; r = p[31:0]; end
      MD_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
      MD_MULHU:  begin p = ua * ub; r = p[63:32]; end
      MD_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else r = 32'(sa / sb);
      end
      MD_DIVU: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else r = a / b;
      end
      MD_REM: begin
        if (b == 0) r = a;
        else if (ovf) r = '0;
        else r = 32'(sa % sb);
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  // Cycles from the accepting edge to the done cycle
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int          k;
`endif
    if (o[2]) begin
      if (b == 0) return 2;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
    end
`ifdef MULDIV_EARLY_OUT_EN
    m = (o == MD_MULH && b[31]) ? -b : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return k + 3;
`else
    return 35;
`endif
  endfunction

  // Called at a negedge in an IDLE cycle; returns at a negedge in the next IDLE cycle
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int sels,
                        output int busy_bad);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    res = 'x; lat = 0; sels = 0; busy_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      if (alu_sel) sels++;
      if (done) begin
        res = result;
        lat = c;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_op(input string name, input int idx, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int lat, sels, bb, el;
    run_op(o, a, b, res, lat, sels, bb);
    el = exp_lat(o, a, b);
    check({name, ".result"}, idx, res, exp);
    check({name, ".latency"}, idx, 32'(lat), 32'(el));
    check({name, ".alu_sel_cycles"}, idx, 32'(sels), 32'((el <= 2) ? 0 : el - 3));
    check({name, ".busy_window"}, idx, 32'(bb), 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, ".busy"}, 0, 32'(busy), 32'd0);
    check({name, ".done"}, 0, 32'(done), 32'd0);
    check({name, ".alu_sel"}, 0, 32'(alu_sel), 32'd0);
    check({name, ".result"}, 0, result, 32'd0);
    check({name, ".alu_ctrl"}, 0, 32'(alu_ctrl), 32'd0);
    check({name, ".alu_op1"}, 0, alu_op1, 32'd0);
    check({name, ".alu_op2"}, 0, alu_op2, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;

    tbl[0]  = '{MD_MUL,    32'd7,          32'd6,          32'd42};
    tbl[1]  = '{MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    tbl[2]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    tbl[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    tbl[4]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    tbl[5]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    tbl[6]  = '{MD_DIVU,   32'd100,        32'd7,          32'd14};
    tbl[7]  = '{MD_REMU,   32'd100,        32'd7,          32'd2};
    tbl[8]  = '{MD_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF};
    tbl[9]  = '{MD_REM,    32'd5,          32'd0,          32'd5};
    tbl[10] = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    tbl[11] = '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    tbl[12] = '{MD_MUL,    32'h1234_5678,  32'd0,          32'd0};
    tbl[13] = '{MD_MULH,   32'h8000_0000,  32'd2,          32'hFFFF_FFFF};

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) do_op("tbl", i, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    // kill together with start in IDLE: nothing accepted
    start = 1'b1; kill = 1'b1; op = MD_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start.busy", 0, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("kill_start.busy_later", 0, 32'(busy), 32'd0);

    // kill in the 10th ITER cycle
    do_op("prior", 0, MD_DIVU, 32'd100, 32'd7, 32'd14);
    start = 1'b1; op = MD_DIVU; rs1 = 32'h1234_5678; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("kill.alu_sel", 0, 32'(alu_sel), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill.busy", 0, 32'(busy), 32'd0);
    check("kill.done", 0, 32'(done), 32'd0);
    check("kill.result", 0, result, 32'd14);
    do_op("after_kill", 0, MD_MUL, 32'd7, 32'd6, 32'd42);

    // asynchronous reset mid-ITER
    start = 1'b1; op = MD_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_op("after_rst", 0, MD_REMU, 32'd100, 32'd7, 32'd2);

    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(0, 15));
        3: a = 32'($urandom_range(0, 255));
        4: b = 32'h8000_0000;
        default: ;
      endcase
      do_op("rand", i, o, a, b, ref_md(o, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
